// File: rtl/hack_rom_loader_if.sv
// Byte stream from the UART receiver and the instruction ROM write port
// driven by the Hack ROM loader.
interface hack_rom_loader_if #(
  parameter int WIDTH = 16,
  parameter int I_AW  = 16
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic [I_AW-1:0]  rom_addr;
  logic [WIDTH-1:0] rom_wdata;
  logic             rom_write;

  modport master (
    input  rx_valid,
    input  rx_data,
    output rom_addr,
    output rom_wdata,
    output rom_write
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  rom_addr,
    input  rom_wdata,
    input  rom_write
  );
endinterface

// File: rtl/hack_rom_loader.sv
// Reloads the Hack instruction ROM from a length-prefixed big-endian byte
// stream while holding the CPU in reset.
//
// state   | meaning
// IDLE    | waiting for start; cpu_reset holds its last value
// LEN_HI  | expecting word count [15:8]
// LEN_LO  | expecting word count [7:0]
// DATA_HI | expecting instruction high byte
// DATA_LO | expecting instruction low byte; writes the word
// DONE    | load complete; releases the CPU next cycle
module hack_rom_loader #(
  parameter int WIDTH          = 16,
  parameter int I_AW           = 16,
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  hack_rom_loader_if.master bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_DONE
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  // Timer reloads to T-1 so the error lands exactly T edges after the byte.
  localparam logic [TW-1:0] TLOAD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0]   MAX_LEN = 33'd1 << I_AW;

  state_t           state, state_d;
  logic [15:0]      len_q, len_d, len_full;
  logic [7:0]       hi_q, hi_d;
  logic [I_AW:0]    idx_q, idx_d, idx_inc;
  logic [TW-1:0]    timer_q, timer_d;
  logic [I_AW-1:0]  rom_addr_q, rom_addr_d;
  logic [WIDTH-1:0] rom_wdata_q, rom_wdata_d;
  logic             rom_write_q, rom_write_d;
  logic             cpu_reset_d, busy_d, done_d, error_d;
  logic             active, last_word, oversize;

  assign idx_inc   = idx_q + {{I_AW{1'b0}}, 1'b1};
  assign len_full  = {len_q[15:8], bus.rx_data};
  assign last_word = (33'(idx_inc) == 33'(len_q));
  assign oversize  = (33'(len_full) > MAX_LEN);
  assign active    = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA_HI) || (state == S_DATA_LO);

  always_comb begin
    state_d     = state;
    len_d       = len_q;
    hi_d        = hi_q;
    idx_d       = idx_q;
    timer_d     = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    rom_write_d = 1'b0;
    cpu_reset_d = cpu_reset;
    busy_d      = busy;
    done_d      = 1'b0;
    error_d     = error;

    if (active && bus.rx_valid) timer_d = TLOAD;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LEN_HI;
          cpu_reset_d = 1'b1;
          busy_d      = 1'b1;
          error_d     = 1'b0;
          idx_d       = '0;
          timer_d     = TLOAD;
        end
      end
      S_LEN_HI: begin
        if (bus.rx_valid) begin
          len_d[15:8] = bus.rx_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (bus.rx_valid) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = S_DONE;
          end else if (oversize) begin
            state_d = S_IDLE;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (bus.rx_valid) begin
          hi_d    = bus.rx_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (bus.rx_valid) begin
          rom_write_d = 1'b1;
          rom_addr_d  = idx_q[I_AW-1:0];
          rom_wdata_d = WIDTH'({hi_q, bus.rx_data});
          idx_d       = idx_inc;
          state_d     = last_word ? S_DONE : S_DATA_HI;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        cpu_reset_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Silence on the link abandons the load; the CPU stays held.
    if (active && !bus.rx_valid && timer_q == '0) begin
      state_d = S_IDLE;
      error_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      len_q       <= '0;
      hi_q        <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      rom_write_q <= 1'b0;
      cpu_reset   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      rom_write_q <= rom_write_d;
      cpu_reset   <= cpu_reset_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign bus.rom_write = rom_write_q;

endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Boot-time controller that reloads the Hack instruction ROM from a byte stream (UART receiver output) without reprogramming the FPGA. On a load request it holds the CPU in reset, receives a 16-bit word count followed by big-endian instruction words, and writes them sequentially from address 0 into the instruction ROM write port. It then releases the CPU. It sits between the UART RX block and the instruction ROM/CPU reset inside the platform top.

## Interface
- WIDTH, 16, instruction word width (byte protocol fixed for 16)
- I_AW, 16, instruction ROM address width
- TIMEOUT_CYCLES, 2700000, max idle cycles between bytes during a load (~100 ms at 27 MHz); ≥2

- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  load request pulse; sampled only in IDLE
- rx_valid  input  1  one-cycle strobe, rx_data valid
- rx_data  input  8  received byte
- rom_addr  output  I_AW  instruction ROM write address
- rom_wdata  output  WIDTH  instruction ROM write data
- rom_write  output  1  instruction ROM write enable, one-cycle pulse per word
- cpu_reset  output  1  CPU hold; ORed with reset at the top level
- busy  output  1  load in progress
- done  output  1  one-cycle pulse on successful load completion
- error  output  1  sticky load failure flag; cleared by next accepted start

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE.
- IDLE: rx_valid ignored. start → LEN_HI; cpu_reset=1, busy=1, error=0, word index=0.
- LEN_HI/LEN_LO: rx_valid latches length[15:8] then length[7:0].
  - In LEN_LO: if length == 0 → DONE.
  - If length > 2**I_AW → IDLE with error=1 and cpu_reset held at 1.
  - Otherwise → DATA_HI.
- DATA_HI: rx_valid latches the high byte → DATA_LO.
- DATA_LO: rx_valid forms the word {hi, rx_data}. In the next cycle: rom_write=1, rom_addr=index, rom_wdata=word. Index increments.
  - If the incremented index == length → DONE; else → DATA_HI.
  - Back-to-back bytes (rx_valid every cycle) are supported; no byte is dropped.
- DONE: one cycle. Next cycle: done=1, busy=0, cpu_reset=0; state → IDLE.
- Timeout: an idle counter clears on every rx_valid and on start, and counts while in LEN_HI..DATA_LO. If it reaches TIMEOUT_CYCLES → IDLE, error=1, cpu_reset stays 1, busy=0. Partially written ROM is never executed. Only a later successful load clears cpu_reset.
- start while busy: ignored. rx_valid coincident with start in IDLE: the byte is ignored.
- Index counter is I_AW+1 bits so length == 2**I_AW terminates correctly. rom_addr is index[I_AW-1:0] and never wraps.

## Timing
- All outputs are registered.
- Reset values: rom_addr=0, rom_wdata=0, rom_write=0, cpu_reset=0, busy=0, done=0, error=0; state=IDLE.
- Reset mid-load: returns immediately to IDLE with the reset values above. The CPU then runs whatever the ROM holds; the platform reset covers the CPU.
- start at cycle t: busy=1 and cpu_reset=1 at t+1.
- Low data byte accepted at t: rom_write pulse at t+1 (single cycle).
- Final low byte (or length low byte with length 0) accepted at t: done=1, busy=0, cpu_reset=0 at t+2.
- Timeout: error=1 and busy=0 exactly TIMEOUT_CYCLES cycles after the last accepted byte (or after start if no byte arrives).

## Test plan
- Nominal: start, bytes 00 03 | 12 34 | AB CD | 00 07 → writes (0,0x1234), (1,0xABCD), (2,0x0007). rom_write pulses exactly 3 times, done one pulse, cpu_reset falls with done, error=0.
- Back-to-back: same stream with rx_valid every cycle → identical writes; each write follows its low byte by 1 cycle.
- Zero length: start, 00 00 → no rom_write. done at t+2 after the second byte, cpu_reset=0.
- Timeout (TIMEOUT_CYCLES=16): start, 00 02, 11 22, then silence → one write (0,0x1122). error=1 and busy=0 16 cycles after the byte 22. cpu_reset stays 1. A following good load clears error and releases cpu_reset.
- Oversize (I_AW=4): length 00 11 (17) → error=1, IDLE, no writes, cpu_reset=1. Length 00 10 (16) → 16 writes at addresses 0..15, done.
- Reset mid-load after 1 word: all outputs return to reset values the next cycle. Subsequent rx_valid bytes and a start during busy produce no writes.
